dac_seq_controller: RTL

DAC_SEQ_CONTROLLER -- requirements
Module: dac_seq_controller

---
 rtl/dac_seq_controller_if.sv | 31 +++
 rtl/dac_seq_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dac_seq_controller_if.sv
// Bundle of sequencer control, table-read and DAC-side signals.
// No latency of its own; pure wiring between host, table RAM and controller.
// Table port assumes a 1-cycle registered read; the controller never stalls.
interface dac_seq_controller_if #(
    parameter int ADDR_W = 10
);
    logic                     start;
    logic                     stop;
    logic [31:0]              samples_per_step;
    logic [ADDR_W:0]          num_steps;
    logic [15:0]              repetitions;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [15:0]       mem_data;
    logic signed [15:0]       seq_out;
    logic                     disable_dac;
    logic                     step_tick;
    logic                     busy;
    logic                     done;

    // Controller side: drives the table address and the DAC-facing outputs.
    modport master (
        input  start, stop, samples_per_step, num_steps, repetitions, mem_data,
        output mem_addr, seq_out, disable_dac, step_tick, busy, done
    );

    // Host / table side: issues commands, returns table words, observes outputs.
    modport slave (
        output start, stop, samples_per_step, num_steps, repetitions, mem_data,
        input  mem_addr, seq_out, disable_dac, step_tick, busy, done
    );
endinterface

// File: rtl/dac_seq_controller.sv
// Plays a table of signed samples to the DAC composer, each held samples_per_step cycles.
// First entry on seq_out two clocks after start is raised; then one entry per hold period.
// No backpressure: start only taken in IDLE, stop aborts LOAD/RUN on the next edge.
module dac_seq_controller #(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  aresetn,
    dac_seq_controller_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   NST_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t                 state, state_nxt;

    // Shadow copies of the configuration, frozen at start.
    logic [31:0]            sps_sh, sps_sh_nxt;
    logic [ADDR_W:0]        nst_sh, nst_sh_nxt;
    logic [15:0]            rep_sh, rep_sh_nxt;

    logic [ADDR_W-1:0]      idx, idx_nxt;
    logic [ADDR_W-1:0]      addr, addr_nxt;
    logic [15:0]            pass_cnt, pass_cnt_nxt;
    logic [31:0]            hold, hold_nxt;
    logic signed [15:0]     seq, seq_nxt;
    logic                   dis, dis_nxt;
    logic                   tick, tick_nxt;

    // Index arithmetic: entry after the current one, and the entry after that
    // (the address has to run one step ahead because of the table read latency).
    logic                   at_last;
    logic                   nidx_last;
    logic [ADDR_W-1:0]      nidx;
    logic [ADDR_W-1:0]      nnidx;
    logic                   final_pass;

    // Wrap-aware successor indices and end-of-sequence detection.
    always_comb begin
        at_last    = ({1'b0, idx} == (nst_sh - NST_ONE));
        nidx       = at_last ? '0 : idx + IDX_ONE;
        nidx_last  = ({1'b0, nidx} == (nst_sh - NST_ONE));
        nnidx      = nidx_last ? '0 : nidx + IDX_ONE;
        // Pass counter holds completed passes; the one finishing now is the last.
        final_pass = at_last && (rep_sh != 16'd0) &&
                     (({1'b0, pass_cnt} + 17'd1) == {1'b0, rep_sh});
    end

    // Next-state and datapath update; every register defaults to holding.
    always_comb begin
        state_nxt    = state;
        sps_sh_nxt   = sps_sh;
        nst_sh_nxt   = nst_sh;
        rep_sh_nxt   = rep_sh;
        idx_nxt      = idx;
        addr_nxt     = addr;
        pass_cnt_nxt = pass_cnt;
        hold_nxt     = hold;
        seq_nxt      = seq;
        dis_nxt      = dis;
        tick_nxt     = 1'b0;

        case (state)
            IDLE: begin
                seq_nxt  = '0;
                dis_nxt  = 1'b1;
                addr_nxt = '0;
                // A zero-length table is not a sequence: ignore the request.
                if (bus.start && (bus.num_steps != '0)) begin
                    // Hold times below 2 would outrun the table read pipeline.
                    sps_sh_nxt = (bus.samples_per_step < 32'd2) ? 32'd2
                                                                : bus.samples_per_step;
                    nst_sh_nxt = bus.num_steps;
                    rep_sh_nxt = bus.repetitions;
                    state_nxt  = LOAD;
                end
            end

            LOAD: begin
                if (bus.stop) begin
                    state_nxt = DONE;
                end else begin
                    // Address 0 has been presented since IDLE, so entry 0 is on mem_data.
                    seq_nxt      = bus.mem_data;
                    dis_nxt      = 1'b0;
                    tick_nxt     = 1'b1;
                    idx_nxt      = '0;
                    addr_nxt     = (nst_sh == NST_ONE) ? '0 : IDX_ONE;
                    hold_nxt     = sps_sh - 32'd1;
                    pass_cnt_nxt = '0;
                    state_nxt    = RUN;
                end
            end

            RUN: begin
                if (bus.stop) begin
                    // Abort wins over a coinciding step boundary.
                    state_nxt = DONE;
                end else if (hold != 32'd0) begin
                    hold_nxt = hold - 32'd1;
                end else if (final_pass) begin
                    state_nxt = DONE;
                end else begin
                    seq_nxt  = bus.mem_data;
                    tick_nxt = 1'b1;
                    idx_nxt  = nidx;
                    addr_nxt = nnidx;
                    hold_nxt = sps_sh - 32'd1;
                    // Endless mode never counts, so the counter cannot wrap.
                    if (at_last && (rep_sh != 16'd0)) begin
                        pass_cnt_nxt = pass_cnt + 16'd1;
                    end
                end
            end

            DONE: begin
                seq_nxt      = '0;
                dis_nxt      = 1'b1;
                addr_nxt     = '0;
                idx_nxt      = '0;
                hold_nxt     = '0;
                pass_cnt_nxt = '0;
                state_nxt    = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops straight to a silent IDLE.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            sps_sh   <= '0;
            nst_sh   <= '0;
            rep_sh   <= '0;
            idx      <= '0;
            addr     <= '0;
            pass_cnt <= '0;
            hold     <= '0;
            seq      <= '0;
            dis      <= 1'b1;
            tick     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sps_sh   <= sps_sh_nxt;
            nst_sh   <= nst_sh_nxt;
            rep_sh   <= rep_sh_nxt;
            idx      <= idx_nxt;
            addr     <= addr_nxt;
            pass_cnt <= pass_cnt_nxt;
            hold     <= hold_nxt;
            seq      <= seq_nxt;
            dis      <= dis_nxt;
            tick     <= tick_nxt;
        end
    end

    assign bus.mem_addr    = addr;
    assign bus.seq_out     = seq;
    assign bus.disable_dac = dis;
    assign bus.step_tick   = tick;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);

endmodule
